sa_tile_sequencer: RTL and testbench
====================================

Name: sa_tile_sequencer

Overview:
- Parametrised successor to the square-array core control logic.
- Sequences one output-stationary tile on a ROWS x COLS PE array: accepts k_len beats of A/W vectors over a valid/ready handshake and applies per-lane skew. Lane i of A is delayed by i fire cycles; lane j of W is delayed by j.
- Drives the array fire and accumulator clear, then drains the pipeline and pulses tile_done.
- Adds what the previous core lacks: rectangular arrays, programmable depth, backpressure-tolerant stalls, optional accumulate-across-tiles, and length error reporting.

Parameters:
- ROWS, 8, A lanes / PE rows.
- COLS, 8, W lanes / PE columns.
- INWIDTH, 8, operand width.
- KMAX, 256, maximum accepted k_len.
- KW, $clog2(KMAX+1), k_len width.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- start  in  1  tile start pulse; sampled only in IDLE.
- k_len  in  KW  beats in the tile; sampled with start.
- accumulate  in  1  1 = suppress arr_clr; sampled with start.
- in_valid  in  1  a_in/w_in beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- a_in  in  ROWS x INWIDTH  A vector.
- w_in  in  COLS x INWIDTH  W vector.
- arr_a  out  ROWS x INWIDTH  skewed A to array west edge.
- arr_w  out  COLS x INWIDTH  skewed W to array north edge.
- arr_fire  out  1  array advance/MAC enable.
- arr_clr  out  1  clear all PE accumulators.
- busy  out  1  state != IDLE.
- tile_done  out  1  one-cycle pulse at tile end.
- err_klen  out  1  one-cycle pulse: start with k_len==0 or k_len>KMAX.

Behaviour:
- Reset: all outputs 0, every skew register 0, state IDLE, all counters 0. Reset is effective mid-tile: it abandons the tile and produces no tile_done.
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE:
  - start with a valid k_len: latch k_len and accumulate, go to CLEAR.
  - start with an invalid k_len: err_klen=1 next cycle, stay in IDLE.
  - start while busy: ignored.
- CLEAR (1 cycle): arr_clr=1 next cycle unless accumulate was latched; go to FEED.
- FEED:
  - in_ready=1.
  - fire_int = in_valid.
  - Beat counter increments on each accepted beat.
  - On accepting beat k_len: go to DRAIN if ROWS+COLS>2, else DONE.
  - in_ready is 0 in the cycle after the last beat.
- DRAIN:
  - in_ready=0, fire_int=1 every cycle, zero injected into skew lanes.
  - Lasts exactly ROWS+COLS-2 cycles (drain counter), then DONE.
- DONE (1 cycle): tile_done=1 next cycle, return to IDLE. busy stays 1 through DONE and drops with tile_done.
- Skew:
  - A lane i is a shift chain of i+1 registers; W lane j is a chain of j+1 registers.
  - All chains shift only when fire_int=1. Stage 0 loads the a_in/w_in lane in FEED and 0 in DRAIN.
  - arr_a[i] and arr_w[j] are the chain tail registers.
- arr_fire is fire_int registered, aligned with the skew register outputs.
- Stall: in_valid=0 during FEED gives fire_int=0. The chains hold and arr_fire=0, so the array and its data are frozen; no bubble ever enters the array.
- Total arr_fire-high cycles per tile = k_len + ROWS + COLS - 2, independent of stalls.
- tile_done rises 1 cycle after the last arr_fire high cycle.
- arr_clr and arr_fire are never high in the same cycle.

Decomposition:
- Package sa_pkg:
  - state enum (IDLE, CLEAR, FEED, DRAIN, DONE);
  - function drain_len(rows, cols) = rows+cols-2;
  - operand typedef parametrised by INWIDTH.
- One sub-module, sa_skew_lane #(DEPTH, WIDTH): enable-gated shift chain with a zero-inject input.
  - Instantiated ROWS times with DEPTH=i+1 and COLS times with DEPTH=j+1 via generate.

Test Plan:
- ROWS=COLS=4, k_len=3, accumulate=0, in_valid held 1, A beats 1,2,3 on every lane:
  - arr_clr is high 1 cycle, then arr_fire is high 9 consecutive cycles;
  - arr_a[0] = 1,2,3,0,...; arr_a[3] = 0,0,0,1,2,3;
  - tile_done pulses 1 cycle after the last arr_fire.
- Same as above with in_valid deasserted 2 cycles after the first beat:
  - arr_fire low exactly those 2 cycles, skew outputs held;
  - arr_fire high-count still 9, tile_done 2 cycles later than before.
- accumulate=1, k_len=5: arr_clr never asserted, 11 arr_fire cycles.
- start with k_len=0, then k_len=257 (KMAX=256): err_klen pulses each time, busy stays 0, no arr_fire.
- rstn=0 for 1 cycle mid-FEED (beat 2 of 4): all outputs 0 the next cycle, state IDLE, no tile_done. A new start then runs a full clean tile.
- ROWS=COLS=1, k_len=2: DRAIN skipped, 2 arr_fire cycles, tile_done. start asserted during busy has no effect.

Source files
------------

// File: rtl/sa_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sa_pkg : shared types and helpers for the systolic tile sequencer |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package sa_pkg;

  localparam int INWIDTH_DEFAULT = 8;

  typedef logic [INWIDTH_DEFAULT-1:0] operand_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Cycles needed after the last beat for it to reach the far corner PE.
  function automatic int drain_len(input int rows, input int cols);
    return rows + cols - 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sa_skew_lane.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sa_skew_lane : enable-gated shift chain with zero injection       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module sa_skew_lane #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             zero,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      chain <= '0;
    end else if (en) begin
      chain[0] <= zero ? '0 : din;
      for (int s = 1; s < DEPTH; s++) begin
        chain[s] <= chain[s-1];
      end
    end
  end

  assign dout = chain[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/sa_tile_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sa_tile_sequencer : feeds one output-stationary tile with skew    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module sa_tile_sequencer
  import sa_pkg::*;
#(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int INWIDTH = INWIDTH_DEFAULT,
  parameter int KMAX    = 256,
  parameter int KW      = $clog2(KMAX + 1)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start,
  input  logic [KW-1:0]                 k_len,
  input  logic                          accumulate,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ROWS-1:0][INWIDTH-1:0]  a_in,
  input  logic [COLS-1:0][INWIDTH-1:0]  w_in,
  output logic [ROWS-1:0][INWIDTH-1:0]  arr_a,
  output logic [COLS-1:0][INWIDTH-1:0]  arr_w,
  output logic                          arr_fire,
  output logic                          arr_clr,
  output logic                          busy,
  output logic                          tile_done,
  output logic                          err_klen
);

  localparam int            DRAIN_CYC  = drain_len(ROWS, COLS);
  localparam int            DW         = $clog2(ROWS + COLS);
  localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);
  localparam logic [KW:0]   KMAX_W     = (KW+1)'(KMAX);

  state_t          state;
  logic [KW-1:0]   klen_r;
  logic            acc_r;
  logic [KW-1:0]   beat_cnt;
  logic [DW-1:0]   drain_cnt;
  logic            klen_ok;
  logic            fire_int;
  logic            zero_inj;

  assign klen_ok  = (k_len != '0) && ({1'b0, k_len} <= KMAX_W);
  assign fire_int = ((state == FEED) && in_valid) || (state == DRAIN);
  assign zero_inj = (state == DRAIN);
  assign in_ready = (state == FEED);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      klen_r    <= '0;
      acc_r     <= 1'b0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      arr_fire  <= 1'b0;
      arr_clr   <= 1'b0;
      tile_done <= 1'b0;
      err_klen  <= 1'b0;
    end else begin
      // arr_fire lands on the same edge as the chain tails it qualifies.
      arr_fire  <= fire_int;
      arr_clr   <= 1'b0;
      tile_done <= 1'b0;
      err_klen  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (klen_ok) begin
              klen_r <= k_len;
              acc_r  <= accumulate;
              state  <= CLEAR;
            end else begin
              err_klen <= 1'b1;
            end
          end
        end
        CLEAR: begin
          arr_clr   <= !acc_r;
          beat_cnt  <= '0;
          drain_cnt <= '0;
          state     <= FEED;
        end
        FEED: begin
          if (in_valid) begin
            beat_cnt <= beat_cnt + KW'(1);
            if (beat_cnt == klen_r - KW'(1)) begin
              state <= (DRAIN_CYC > 0) ? DRAIN : DONE;
            end
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + DW'(1);
          if (drain_cnt == DRAIN_LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          tile_done <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_a_lane
    sa_skew_lane #(.DEPTH(i + 1), .WIDTH(INWIDTH)) u_lane (
      .clk  (clk),
      .rstn (rstn),
      .en   (fire_int),
      .zero (zero_inj),
      .din  (a_in[i]),
      .dout (arr_a[i])
    );
  end

  for (genvar j = 0; j < COLS; j++) begin : g_w_lane
    sa_skew_lane #(.DEPTH(j + 1), .WIDTH(INWIDTH)) u_lane (
      .clk  (clk),
      .rstn (rstn),
      .en   (fire_int),
      .zero (zero_inj),
      .din  (w_in[j]),
      .dout (arr_w[j])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_sa_tile_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sa_tile_sequencer : self-checking bench for sa_tile_sequencer  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_sa_tile_sequencer;

  localparam int R    = 4;
  localparam int C    = 4;
  localparam int W    = 8;
  localparam int KMAX = 256;
  localparam int KW   = $clog2(KMAX + 1);

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic                 start, accumulate, in_valid, in_ready;
  logic [KW-1:0]        k_len;
  logic [R-1:0][W-1:0]  a_in, arr_a;
  logic [C-1:0][W-1:0]  w_in, arr_w;
  logic                 arr_fire, arr_clr, busy, tile_done, err_klen;

  logic                 start_s, acc_s, in_valid_s, in_ready_s;
  logic [KW-1:0]        k_len_s;
  logic [0:0][W-1:0]    a_in_s, arr_a_s, w_in_s, arr_w_s;
  logic                 arr_fire_s, arr_clr_s, busy_s, tile_done_s, err_klen_s;

  sa_tile_sequencer #(.ROWS(R), .COLS(C), .INWIDTH(W), .KMAX(KMAX)) dut (
    .clk(clk), .rstn(rstn), .start(start), .k_len(k_len), .accumulate(accumulate),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .w_in(w_in),
    .arr_a(arr_a), .arr_w(arr_w), .arr_fire(arr_fire), .arr_clr(arr_clr),
    .busy(busy), .tile_done(tile_done), .err_klen(err_klen)
  );

  sa_tile_sequencer #(.ROWS(1), .COLS(1), .INWIDTH(W), .KMAX(KMAX)) dut_s (
    .clk(clk), .rstn(rstn), .start(start_s), .k_len(k_len_s), .accumulate(acc_s),
    .in_valid(in_valid_s), .in_ready(in_ready_s), .a_in(a_in_s), .w_in(w_in_s),
    .arr_a(arr_a_s), .arr_w(arr_w_s), .arr_fire(arr_fire_s), .arr_clr(arr_clr_s),
    .busy(busy_s), .tile_done(tile_done_s), .err_klen(err_klen_s)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [R-1:0][W-1:0] a_hist[$];
  logic [C-1:0][W-1:0] w_hist[$];

  typedef struct {
    int k;
    bit acc;
    int stall_pct;
    bit exp_err;
    int exp_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Array edge after f fires: lane i carries beat f-i (1-based), else zero.
  function automatic logic [R-1:0][W-1:0] exp_a(input int f, input int k);
    logic [R-1:0][W-1:0] v = '0;
    for (int i = 0; i < R; i++) begin
      int b = f - i;
      if (b >= 1 && b <= k && b <= a_hist.size()) v[i] = a_hist[b-1][i];
    end
    return v;
  endfunction

  function automatic logic [C-1:0][W-1:0] exp_w(input int f, input int k);
    logic [C-1:0][W-1:0] v = '0;
    for (int j = 0; j < C; j++) begin
      int b = f - j;
      if (b >= 1 && b <= k && b <= w_hist.size()) v[j] = w_hist[b-1][j];
    end
    return v;
  endfunction

  task automatic run_err(input int k);
    @(negedge clk);
    start = 1'b1; k_len = KW'(k); accumulate = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("err_klen_pulse", 64'(err_klen), 64'd1);
    chk("err_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("err_klen_clears", 64'(err_klen), 64'd0);
    chk("err_no_fire", 64'(arr_fire), 64'd0);
    chk("err_busy2", 64'(busy), 64'd0);
  endtask

  task automatic run_tile(input int k, input bit acc, input bit ramp, input int stall_pct,
                          input int stall_after, input int stall_len, input int abort_beat,
                          output int lat);
    int  beat = 0, fidx = 0, clrs = 0, cyc = 0, stall_rem = stall_len;
    int  budget = k * 10 + 100;
    bit  done = 0, last_fire = 0;
    a_hist.delete();
    w_hist.delete();
    lat = 0;
    @(negedge clk);
    start = 1'b1; k_len = KW'(k); accumulate = acc; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; k_len = KW'($urandom_range(300)); accumulate = 1'($urandom_range(1));
    while (!done && cyc < budget) begin
      cyc++;
      if (arr_fire) fidx++;
      if (arr_clr) clrs++;
      chk("arr_a", 64'(arr_a), 64'(exp_a(fidx, k)));
      chk("arr_w", 64'(arr_w), 64'(exp_w(fidx, k)));
      chk("clr_fire_overlap", 64'(arr_fire & arr_clr), 64'd0);
      if (tile_done) begin
        done = 1;
        lat  = cyc;
        chk("fire_count", 64'(fidx), 64'(k + R + C - 2));
        chk("clr_count", 64'(clrs), acc ? 64'd0 : 64'd1);
        chk("done_after_last_fire", 64'(last_fire), 64'd1);
        chk("busy_drops_with_done", 64'(busy), 64'd0);
      end else if (abort_beat > 0 && beat >= abort_beat) begin
        rstn = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_arr_a", 64'(arr_a), 64'd0);
        chk("rst_arr_w", 64'(arr_w), 64'd0);
        chk("rst_outs", {58'd0, arr_fire, arr_clr, busy, tile_done, err_klen, in_ready}, 64'd0);
        rstn = 1'b1;
        repeat (6) begin
          @(negedge clk);
          chk("abort_no_done", {62'd0, tile_done, arr_fire}, 64'd0);
          chk("abort_idle", 64'(busy), 64'd0);
        end
        done = 1;
      end else begin
        chk("busy_in_tile", 64'(busy), 64'd1);
        if (beat == k) chk("ready_after_last", 64'(in_ready), 64'd0);
        if (in_ready && beat < k) begin
          if (stall_after > 0 && beat == stall_after && stall_rem > 0) begin
            in_valid = 1'b0;
            stall_rem--;
          end else begin
            in_valid = ($urandom_range(99) >= stall_pct);
          end
        end else begin
          in_valid = 1'($urandom_range(1));
        end
        for (int i = 0; i < R; i++) a_in[i] = ramp ? W'(beat + 1) : W'($urandom);
        for (int j = 0; j < C; j++) w_in[j] = ramp ? W'(beat + 1) : W'($urandom);
        if (in_valid && in_ready && beat < k) begin
          a_hist.push_back(a_in);
          w_hist.push_back(w_in);
          beat++;
        end
        last_fire = arr_fire;
        @(negedge clk);
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tile_timeout: got no tile_done within %0d cycles (k=%0d)", budget, k);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int lat, lat_base, lat_stall;

    vecs[0] = '{k: 3,   acc: 0, stall_pct: 0,  exp_err: 0, exp_lat: 12};
    vecs[1] = '{k: 5,   acc: 1, stall_pct: 0,  exp_err: 0, exp_lat: 14};
    vecs[2] = '{k: 1,   acc: 0, stall_pct: 0,  exp_err: 0, exp_lat: 10};
    vecs[3] = '{k: 0,   acc: 0, stall_pct: 0,  exp_err: 1, exp_lat: -1};
    vecs[4] = '{k: 257, acc: 0, stall_pct: 0,  exp_err: 1, exp_lat: -1};
    vecs[5] = '{k: 256, acc: 0, stall_pct: 0,  exp_err: 0, exp_lat: 265};
    vecs[6] = '{k: 7,   acc: 0, stall_pct: 40, exp_err: 0, exp_lat: -1};
    vecs[7] = '{k: 12,  acc: 1, stall_pct: 60, exp_err: 0, exp_lat: -1};
    vecs[8] = '{k: 256, acc: 1, stall_pct: 25, exp_err: 0, exp_lat: -1};

    rstn = 1'b0; start = 1'b0; k_len = '0; accumulate = 1'b0; in_valid = 1'b0;
    a_in = '0; w_in = '0;
    start_s = 1'b0; k_len_s = '0; acc_s = 1'b0; in_valid_s = 1'b0; a_in_s = '0; w_in_s = '0;
    repeat (3) @(negedge clk);
    chk("reset_arr_a", 64'(arr_a), 64'd0);
    chk("reset_arr_w", 64'(arr_w), 64'd0);
    chk("reset_outs", {58'd0, arr_fire, arr_clr, busy, tile_done, err_klen, in_ready}, 64'd0);
    chk("reset_outs_1x1", {56'd0, arr_a_s, arr_fire_s, arr_clr_s, busy_s, tile_done_s,
                           err_klen_s, in_ready_s, 2'b00}, 64'd0);
    rstn = 1'b1;

    foreach (vecs[v]) begin
      if (vecs[v].exp_err) begin
        run_err(vecs[v].k);
      end else begin
        run_tile(vecs[v].k, vecs[v].acc, 1'b0, vecs[v].stall_pct, 0, 0, 0, lat);
        if (vecs[v].exp_lat >= 0) chk("tile_latency", 64'(lat), 64'(vecs[v].exp_lat));
      end
    end

    // Ramp beats 1,2,3 on every lane, then the same with a 2-cycle stall after beat 1.
    run_tile(3, 1'b0, 1'b1, 0, 0, 0, 0, lat_base);
    chk("ramp_latency", 64'(lat_base), 64'd12);
    run_tile(3, 1'b0, 1'b1, 0, 1, 2, 0, lat_stall);
    chk("stall_latency", 64'(lat_stall), 64'(lat_base + 2));

    // Reset after beat 2 of 4, then a clean tile.
    run_tile(4, 1'b0, 1'b1, 0, 0, 0, 2, lat);
    run_tile(4, 1'b0, 1'b0, 0, 0, 0, 0, lat);
    chk("post_abort_latency", 64'(lat), 64'd13);

    for (int t = 0; t < 12; t++) begin
      run_tile(int'($urandom_range(1, 24)), 1'($urandom_range(1)), 1'b0,
               int'($urandom_range(0, 70)), 0, 0, 0, lat);
    end

    // 1x1 array: no drain, start while busy ignored.
    @(negedge clk);
    start_s = 1'b1; k_len_s = KW'(2); acc_s = 1'b0;
    @(negedge clk);
    start_s = 1'b0;
    chk("s_busy_clear", 64'(busy_s), 64'd1);
    @(negedge clk);
    chk("s_clr", 64'(arr_clr_s), 64'd1);
    chk("s_ready", 64'(in_ready_s), 64'd1);
    in_valid_s = 1'b1; a_in_s = 8'h11; w_in_s = 8'h22; start_s = 1'b1; k_len_s = KW'(5);
    @(negedge clk);
    chk("s_fire1", 64'(arr_fire_s), 64'd1);
    chk("s_a1", 64'(arr_a_s), 64'h11);
    chk("s_w1", 64'(arr_w_s), 64'h22);
    a_in_s = 8'h33; w_in_s = 8'h44;
    @(negedge clk);
    chk("s_fire2", 64'(arr_fire_s), 64'd1);
    chk("s_a2", 64'(arr_a_s), 64'h33);
    chk("s_w2", 64'(arr_w_s), 64'h44);
    chk("s_ready_after_last", 64'(in_ready_s), 64'd0);
    in_valid_s = 1'b0; start_s = 1'b0;
    @(negedge clk);
    chk("s_done", 64'(tile_done_s), 64'd1);
    chk("s_fire_off", 64'(arr_fire_s), 64'd0);
    chk("s_busy_at_done", 64'(busy_s), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("s_no_restart", {62'd0, busy_s, tile_done_s}, 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
